// File: rtl/adder_tree_pkg.sv
// Shared types and elaboration-time helpers for the adder tree scheduler.
// No logic here. Only constant functions and the scheduler state encoding.
// No flow control. Every consumer evaluates these at elaboration.
package adder_tree_pkg;

  // Scheduler modes: issuing, waiting for the tree to empty, parked.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } sched_state_e;

  // Number of binary reduction levels needed to fold n operands into one.
  function automatic int TreeStageCount(input int n);
    int s;
    s = 0;
    for (int w = 1; w < n; w = w * 2) begin
      s = s + 1;
    end
    return s;
  endfunction

  // A sum of n unsigned w-bit operands grows by one bit per reduction level.
  function automatic int TreeResW(input int w, input int n);
    return w + TreeStageCount(n);
  endfunction

  // Default tree latency: one register per reduction level.
  function automatic int TreeLat(input int n);
    return TreeStageCount(n);
  endfunction

endpackage

// File: rtl/adder_tree_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// Latency: grant is combinational; the pointer advances on the clock edge after a grant.
// Backpressure: i_en low forces no grant and freezes the pointer; requests simply wait.
module rr_arbiter #(
  parameter int REQ_N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQ_N-1:0]         i_req,
  input  logic                     i_en,
  output logic [REQ_N-1:0]         o_gnt,
  output logic [$clog2(REQ_N)-1:0] o_gnt_idx
);

  localparam int IDX_W = $clog2(REQ_N);

  logic [IDX_W-1:0]                  ptr;
  logic [REQ_N-1:0][IDX_W-1:0]       cand_idx;
  logic                              gnt_found;

  // Reduce a value in 0..2*REQ_N-2 back into 0..REQ_N-1.
  function automatic int wrap_idx(input int v);
    return (v >= REQ_N) ? (v - REQ_N) : v;
  endfunction

  // Search order: ptr, ptr+1, ... wrapping modulo REQ_N (REQ_N need not be a power of two).
  always_comb begin
    for (int i = 0; i < REQ_N; i++) begin
      cand_idx[i] = IDX_W'(wrap_idx(int'(ptr) + i));
    end
  end

  // Pick the first active request in search order.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < REQ_N; i++) begin
      if (i_en && !gnt_found && i_req[cand_idx[i]]) begin
        gnt_found            = 1'b1;
        o_gnt[cand_idx[i]]   = 1'b1;
        o_gnt_idx            = cand_idx[i];
      end
    end
  end

  // Pointer moves one past the winner so the winner becomes lowest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_found) begin
      if (o_gnt_idx == IDX_W'(REQ_N - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= o_gnt_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one pipelined adder tree among REQ_N requesters.
// Latency: grant comb at t, tree input at t+1, o_res_vld/o_res_id at t+1+TREE_LAT.
// Backpressure: none on results (sink must accept); requests wait unserved; i_hold drains then parks.
// Optional ADDER_TREE_SCHED_STATS_EN adds saturating grant and stall counters.
module adder_tree_sched
  import adder_tree_pkg::*;
#(
  parameter  int REQ_N    = 4,
  parameter  int I_DATA_N = 8,
  parameter  int I_DATA_W = 3,
  parameter  int TREE_LAT = 3,
  localparam int RES_W    = TreeResW(I_DATA_W, I_DATA_N),
  localparam int IDX_W    = $clog2(REQ_N)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [REQ_N-1:0]                              i_req,
  input  logic [0:REQ_N-1][0:I_DATA_N-1][I_DATA_W-1:0]  i_data,
  output logic [REQ_N-1:0]                              o_gnt,
  output logic [0:I_DATA_N-1][I_DATA_W-1:0]             o_tree_data,
  input  logic [RES_W-1:0]                              i_tree_res,
  output logic [RES_W-1:0]                              o_res,
  output logic                                          o_res_vld,
  output logic [IDX_W-1:0]                              o_res_id,
  input  logic                                          i_hold,
`ifdef ADDER_TREE_SCHED_STATS_EN
  output logic [REQ_N-1:0][15:0]                        o_gnt_cnt,
  output logic [15:0]                                   o_stall_cnt,
`endif
  output logic                                          o_idle
);

  sched_state_e                 state;
  sched_state_e                 state_nxt;
  logic                         arb_en;
  logic [IDX_W-1:0]             gnt_idx;
  logic                         gnt_vld;
  logic [TREE_LAT:0]            sl_vld;
  logic [TREE_LAT:0][IDX_W-1:0] sl_id;
  logic                         inflight_after;

  // Grants are suppressed during reset so nothing is accepted that would be lost.
  rr_arbiter #(
    .REQ_N (REQ_N)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_en      (arb_en && !rst),
    .o_gnt     (o_gnt),
    .o_gnt_idx (gnt_idx)
  );

  assign gnt_vld = |o_gnt;

  // Stage TREE_LAT is the entry being delivered this cycle; once it leaves,
  // the line is empty if no lower stage holds a valid entry.
  assign inflight_after = |sl_vld[TREE_LAT-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grant enable; a hold request blocks the grant in the same cycle.
  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    case (state)
      RUN: begin
        if (i_hold) begin
          state_nxt = DRAIN;
        end else begin
          arb_en = 1'b1;
        end
      end
      DRAIN: begin
        if (!inflight_after) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!i_hold) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign o_idle = (state == HOLD);

  // Tree input register: granted vector, or zeros which the tree sums harmlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tree_data <= '0;
    end else if (gnt_vld) begin
      o_tree_data <= i_data[gnt_idx];
    end else begin
      o_tree_data <= '0;
    end
  end

  // Valid/owner shift line that tracks each issue alongside the untagged tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      sl_vld <= '0;
      sl_id  <= '0;
    end else begin
      sl_vld <= {sl_vld[TREE_LAT-1:0], gnt_vld};
      sl_id  <= {sl_id[TREE_LAT-1:0], gnt_idx};
    end
  end

  assign o_res_vld = sl_vld[TREE_LAT];
  assign o_res_id  = sl_id[TREE_LAT];
  assign o_res     = i_tree_res;

`ifdef ADDER_TREE_SCHED_STATS_EN
  // Saturating per-requester grant counters and a stall counter for cycles
  // where someone was asking but nobody was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_gnt_cnt   <= '0;
      o_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < REQ_N; i++) begin
        if (o_gnt[i] && (o_gnt_cnt[i] != 16'hFFFF)) begin
          o_gnt_cnt[i] <= o_gnt_cnt[i] + 16'd1;
        end
      end
      if ((|i_req) && !gnt_vld && (o_stall_cnt != 16'hFFFF)) begin
        o_stall_cnt <= o_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_tree_sched.sv
// Self-checking bench for adder_tree_sched with a behavioural tree and result scoreboard.
// Latency: tree modelled as TREE_LAT registered sum stages after o_tree_data.
// Backpressure: none; every o_res_vld pulse is popped and compared immediately.
module tb_adder_tree_sched;
  import adder_tree_pkg::*;

  localparam int REQ_N    = 4;
  localparam int I_DATA_N = 8;
  localparam int I_DATA_W = 3;
  localparam int TREE_LAT = 3;
  localparam int RES_W    = TreeResW(I_DATA_W, I_DATA_N);
  localparam int IDX_W    = $clog2(REQ_N);

  logic                                          clk = 1'b0;
  logic                                          rst;
  logic [REQ_N-1:0]                              i_req;
  logic [0:REQ_N-1][0:I_DATA_N-1][I_DATA_W-1:0]  i_data;
  logic [REQ_N-1:0]                              o_gnt;
  logic [0:I_DATA_N-1][I_DATA_W-1:0]             o_tree_data;
  logic [RES_W-1:0]                              i_tree_res;
  logic [RES_W-1:0]                              o_res;
  logic                                          o_res_vld;
  logic [IDX_W-1:0]                              o_res_id;
  logic                                          i_hold;
  logic                                          o_idle;
`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [REQ_N-1:0][15:0]                        o_gnt_cnt;
  logic [15:0]                                   o_stall_cnt;
`endif

  adder_tree_sched #(
    .REQ_N    (REQ_N),
    .I_DATA_N (I_DATA_N),
    .I_DATA_W (I_DATA_W),
    .TREE_LAT (TREE_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_data      (i_data),
    .o_gnt       (o_gnt),
    .o_tree_data (o_tree_data),
    .i_tree_res  (i_tree_res),
    .o_res       (o_res),
    .o_res_vld   (o_res_vld),
    .o_res_id    (o_res_id),
    .i_hold      (i_hold),
`ifdef ADDER_TREE_SCHED_STATS_EN
    .o_gnt_cnt   (o_gnt_cnt),
    .o_stall_cnt (o_stall_cnt),
`endif
    .o_idle      (o_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sum;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vec_cnt      = 0;
  int   err_cnt      = 0;
  int   cyc          = 0;
  int   pulse_cnt    = 0;
  int   last_vld_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural tree: sum of the registered input, TREE_LAT registers deep.
  logic [TREE_LAT-1:0][RES_W-1:0] tp = '0;

  function automatic logic [RES_W-1:0] tree_sum(input logic [0:I_DATA_N-1][I_DATA_W-1:0] v);
    logic [RES_W-1:0] s;
    s = '0;
    for (int j = 0; j < I_DATA_N; j++) s = s + RES_W'(v[j]);
    return s;
  endfunction

  always @(posedge clk) tp <= {tp[TREE_LAT-2:0], tree_sum(o_tree_data)};
  assign i_tree_res = tp[TREE_LAT-1];

  function automatic int sum_of(input int k);
    int s;
    s = 0;
    for (int j = 0; j < I_DATA_N; j++) s = s + int'(i_data[k][j]);
    return s;
  endfunction

  // Result monitor: every pulse must match the oldest expected issue.
  always @(negedge clk) begin
    if (o_res_vld === 1'b1) begin
      pulse_cnt    = pulse_cnt + 1;
      last_vld_cyc = cyc;
      vec_cnt      = vec_cnt + 1;
      if (sb.size() == 0) begin
        err_cnt = err_cnt + 1;
        $display("FAIL unexpected_result: cyc=%0d id=%0d res=%0d, required no pulse", cyc, o_res_id, o_res);
      end else begin
        mon_e = sb.pop_front();
        if (o_res_id !== IDX_W'(mon_e.id) || o_res !== RES_W'(mon_e.sum) || cyc != mon_e.due) begin
          err_cnt = err_cnt + 1;
          $display("FAIL result: cyc=%0d id=%0d res=%0d, required cyc=%0d id=%0d res=%0d",
                   cyc, o_res_id, o_res, mon_e.due, mon_e.id, mon_e.sum);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id  = id;
    e.sum = sum_of(id);
    e.due = cyc + TREE_LAT + 1;
    sb.push_back(e);
  endtask

  task automatic randomize_data();
    for (int k = 0; k < REQ_N; k++)
      for (int j = 0; j < I_DATA_N; j++)
        i_data[k][j] = I_DATA_W'($urandom_range(0, (1 << I_DATA_W) - 1));
  endtask

  task automatic drain();
    for (int n = 0; n < 20; n++) begin
      if (sb.size() == 0) break;
      tick();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 4'b1111; i_hold = 1'b0;
    randomize_data();
    tick();
    tick();
    @(negedge clk);
    vec_cnt += 5;
    if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL reset_gnt: got %b, required 0000", o_gnt); end
    if (o_res_vld !== 1'b0) begin err_cnt++; $display("FAIL reset_res_vld: got %b, required 0", o_res_vld); end
    if (o_res_id !== 2'd0) begin err_cnt++; $display("FAIL reset_res_id: got %0d, required 0", o_res_id); end
    if (o_idle !== 1'b0) begin err_cnt++; $display("FAIL reset_idle: got %b, required 0", o_idle); end
    if (o_tree_data !== '0) begin err_cnt++; $display("FAIL reset_tree_data: got %h, required 0", o_tree_data); end
    tick();
    rst = 1'b0; i_req = 4'b0000;
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] g;
    randomize_data();
    i_req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = 4'b0001 << (i % 4);
      vec_cnt++;
      if (o_gnt !== g) begin err_cnt++; $display("FAIL fair_gnt[%0d]: got %b, required %b", i, o_gnt, g); end
      push_exp(i % 4);
      tick();
    end
    i_req = 4'b0000;
    drain();
    vec_cnt++;
    if (sb.size() != 0) begin err_cnt++; $display("FAIL fair_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_single();
    randomize_data();
    for (int j = 0; j < I_DATA_N; j++) i_data[1][j] = 3'd7;
    i_req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_gnt !== 4'b0010) begin err_cnt++; $display("FAIL single_gnt[%0d]: got %b, required 0010", i, o_gnt); end
      sb.push_back('{id: 1, sum: 56, due: cyc + 4});
      tick();
    end
    i_req = 4'b0000;
    drain();
    vec_cnt++;
    if (sb.size() != 0) begin err_cnt++; $display("FAIL single_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] seq_req [4];
    logic [3:0] seq_gnt [4];
    int         seq_id  [4];
    randomize_data();
    // First step parks the pointer at 3; the last step proves it is back at 3.
    seq_req = '{4'b0100, 4'b0101, 4'b0101, 4'b1111};
    seq_gnt = '{4'b0100, 4'b0001, 4'b0100, 4'b1000};
    seq_id  = '{2, 0, 2, 3};
    for (int i = 0; i < 4; i++) begin
      i_req = seq_req[i];
      @(negedge clk);
      vec_cnt++;
      if (o_gnt !== seq_gnt[i]) begin err_cnt++; $display("FAIL wrap_gnt[%0d]: got %b, required %b", i, o_gnt, seq_gnt[i]); end
      push_exp(seq_id[i]);
      tick();
    end
    i_req = 4'b0000;
    drain();
    vec_cnt++;
    if (sb.size() != 0) begin err_cnt++; $display("FAIL wrap_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_hold();
    int pc0;
    int idle_cyc;
    bit idle_seen;
    randomize_data();
    i_req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_gnt !== (4'b0001 << i)) begin err_cnt++; $display("FAIL hold_pre_gnt[%0d]: got %b", i, o_gnt); end
      push_exp(i);
      tick();
    end
    pc0 = pulse_cnt;
    i_hold = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL hold_first_gnt: got %b, required 0000", o_gnt); end
    tick();
    idle_seen = 1'b0;
    idle_cyc  = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL drain_gnt[%0d]: got %b, required 0000", n, o_gnt); end
      if (o_idle === 1'b1) begin
        idle_seen = 1'b1;
        idle_cyc  = cyc;
        break;
      end
      tick();
    end
    vec_cnt += 3;
    if (!idle_seen) begin err_cnt++; $display("FAIL hold_idle_timeout: idle not seen within 20 cycles"); end
    if (pulse_cnt - pc0 != 3) begin err_cnt++; $display("FAIL hold_pulses: got %0d, required 3", pulse_cnt - pc0); end
    if (idle_cyc != last_vld_cyc + 1) begin err_cnt++; $display("FAIL hold_idle_cycle: got %0d, required %0d", idle_cyc, last_vld_cyc + 1); end
    tick();
    @(negedge clk);
    vec_cnt++;
    if (o_idle !== 1'b1 || o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL hold_park: idle=%b gnt=%b, required 1/0000", o_idle, o_gnt); end
    tick();
    i_hold = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL release_cycle_gnt: got %b, required 0000", o_gnt); end
    tick();
    @(negedge clk);
    vec_cnt++;
    if (o_gnt !== 4'b1000 || o_idle !== 1'b0) begin err_cnt++; $display("FAIL resume: gnt=%b idle=%b, required 1000/0", o_gnt, o_idle); end
    push_exp(3);
    tick();
    i_req = 4'b0000;
    drain();
    vec_cnt++;
    if (sb.size() != 0) begin err_cnt++; $display("FAIL hold_drain: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int pc0;
    randomize_data();
    i_req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (o_gnt !== (4'b0001 << i)) begin err_cnt++; $display("FAIL pre_rst_gnt[%0d]: got %b", i, o_gnt); end
      tick();
    end
    pc0 = pulse_cnt;
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (o_gnt !== 4'b0000) begin err_cnt++; $display("FAIL rst_gnt: got %b, required 0000", o_gnt); end
    tick();
    rst = 1'b0; i_req = 4'b0000;
    for (int n = 0; n < 8; n++) tick();
    vec_cnt++;
    if (pulse_cnt != pc0) begin err_cnt++; $display("FAIL rst_discard: got %0d pulses, required 0", pulse_cnt - pc0); end
    i_req = 4'b1111;
    @(negedge clk);
    vec_cnt++;
    if (o_gnt !== 4'b0001) begin err_cnt++; $display("FAIL rst_ptr: got %b, required 0001", o_gnt); end
    push_exp(0);
    tick();
    i_req = 4'b0000;
    drain();
    vec_cnt++;
    if (sb.size() != 0) begin err_cnt++; $display("FAIL rst_drain: %0d pending, required 0", sb.size()); end
  endtask

`ifdef ADDER_TREE_SCHED_STATS_EN
  task automatic test_stats();
    randomize_data();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req = 4'b0001;
    for (int n = 0; n < 70000; n++) begin
      push_exp(0);
      tick();
    end
    i_hold = 1'b1;
    for (int n = 0; n < 10; n++) tick();
    @(negedge clk);
    vec_cnt += 3;
    if (o_gnt_cnt[0] !== 16'hFFFF) begin err_cnt++; $display("FAIL gnt_cnt0: got %h, required ffff", o_gnt_cnt[0]); end
    if (o_gnt_cnt[1] !== 16'h0000) begin err_cnt++; $display("FAIL gnt_cnt1: got %h, required 0000", o_gnt_cnt[1]); end
    if (o_stall_cnt !== 16'd10) begin err_cnt++; $display("FAIL stall_cnt: got %0d, required 10", o_stall_cnt); end
    tick();
    i_hold = 1'b0; i_req = 4'b0000;
    drain();
    vec_cnt++;
    if (sb.size() != 0) begin err_cnt++; $display("FAIL stats_drain: %0d pending, required 0", sb.size()); end
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    i_req  = '0;
    i_hold = 1'b0;
    i_data = '0;
    test_reset();
    test_fairness();
    test_single();
    test_wrap_skip();
    test_hold();
    test_reset_mid();
`ifdef ADDER_TREE_SCHED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
